// File: rtl/phase_clock_gen_if.sv
// Control and phase-output bundle for phase_clock_gen. The controller drives run/divide
// requests through the master modport, and the generator drives the phase outputs through the slave modport.
interface phase_clock_gen_if #(
    parameter int N_PHASES = 2,
    parameter int DIV_W    = 8
);
    logic                en;
    logic [DIV_W-1:0]    divVal;
    logic                divLoad;
    logic [N_PHASES-1:0] phaseClk;
    logic [N_PHASES-1:0] phaseStart;
    logic                cycleDone;
    logic                running;
    logic                divBusy;

    modport master (
        output en, divVal, divLoad,
        input  phaseClk, phaseStart, cycleDone, running, divBusy
    );

    modport slave (
        input  en, divVal, divLoad,
        output phaseClk, phaseStart, cycleDone, running, divBusy
    );
endinterface

// File: rtl/phase_clock_gen.sv
// N-phase one-hot rotating clock-phase generator with a runtime slot length.
// Divide changes are held pending and applied only at the full-cycle boundary.
module phase_clock_gen #(
    parameter int N_PHASES  = 2,
    parameter int DIV_W     = 8,
    parameter int DIV_RESET = 1
) (
    input  logic              clkIn,
    input  logic              rstN,
    phase_clock_gen_if.slave  bus
);
    localparam int                 IDX_W       = $clog2(N_PHASES);
    localparam logic [DIV_W-1:0]   DIV_ONE     = {{(DIV_W-1){1'b0}}, 1'b1};
    localparam logic [DIV_W-1:0]   DIV_RST_V   = DIV_W'(DIV_RESET);
    localparam logic [IDX_W-1:0]   LAST_IDX    = IDX_W'(N_PHASES - 1);
    localparam logic [N_PHASES-1:0] ONEHOT_LSB = {{(N_PHASES-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e             state_q,     state_d;
    logic [IDX_W-1:0]   phase_idx_q, phase_idx_d;
    logic [DIV_W-1:0]   slot_cnt_q,  slot_cnt_d;
    logic [DIV_W-1:0]   div_cur_q,   div_cur_d;
    logic [DIV_W-1:0]   div_pend_q,  div_pend_d;
    logic               pend_q,      pend_d;

    logic [DIV_W-1:0]    div_req_s;
    logic                slot_end_s;
    logic                last_phase_s;
    logic                boundary_s;
    logic [N_PHASES-1:0] phase_clk_s;
    logic [N_PHASES-1:0] phase_start_s;

    // A requested slot length of zero is treated as one.
    function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] v);
        return (v == {DIV_W{1'b0}}) ? DIV_ONE : v;
    endfunction

    // Slot/cycle boundary decode and output decode from registered state only.
    always_comb begin
        div_req_s     = clamp_div(bus.divVal);
        slot_end_s    = (slot_cnt_q == (div_cur_q - DIV_ONE));
        last_phase_s  = (phase_idx_q == LAST_IDX);
        boundary_s    = (state_q == ST_RUN) && slot_end_s && last_phase_s;
        phase_clk_s   = {N_PHASES{1'b0}};
        phase_start_s = {N_PHASES{1'b0}};
        if (state_q == ST_RUN) begin
            phase_clk_s = ONEHOT_LSB << phase_idx_q;
            if (slot_cnt_q == {DIV_W{1'b0}}) begin
                phase_start_s = ONEHOT_LSB << phase_idx_q;
            end else begin
                phase_start_s = {N_PHASES{1'b0}};
            end
        end else begin
            phase_clk_s   = {N_PHASES{1'b0}};
            phase_start_s = {N_PHASES{1'b0}};
        end
    end

    // Next-state logic: slot counting, phase rotation, divide staging, start/stop.
    always_comb begin
        state_d     = state_q;
        phase_idx_d = phase_idx_q;
        slot_cnt_d  = slot_cnt_q;
        div_cur_d   = div_cur_q;
        div_pend_d  = div_pend_q;
        pend_d      = pend_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.divLoad) begin
                    div_cur_d = div_req_s;
                end else begin
                    div_cur_d = div_cur_q;
                end
                if (bus.en) begin
                    state_d     = ST_RUN;
                    phase_idx_d = {IDX_W{1'b0}};
                    slot_cnt_d  = {DIV_W{1'b0}};
                end else begin
                    state_d     = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (!slot_end_s) begin
                    slot_cnt_d = slot_cnt_q + DIV_ONE;
                end else if (!last_phase_s) begin
                    phase_idx_d = phase_idx_q + IDX_W'(1);
                    slot_cnt_d  = {DIV_W{1'b0}};
                end else begin
                    // Cycle boundary: a same-cycle load beats an older pending value.
                    phase_idx_d = {IDX_W{1'b0}};
                    slot_cnt_d  = {DIV_W{1'b0}};
                    if (bus.divLoad) begin
                        div_cur_d = div_req_s;
                        pend_d    = 1'b0;
                    end else if (pend_q) begin
                        div_cur_d = div_pend_q;
                        pend_d    = 1'b0;
                    end else begin
                        div_cur_d = div_cur_q;
                    end
                    state_d = bus.en ? ST_RUN : ST_IDLE;
                end
                if (bus.divLoad && !boundary_s) begin
                    div_pend_d = div_req_s;
                    pend_d     = 1'b1;
                end else begin
                    div_pend_d = div_pend_q;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                phase_idx_d = {IDX_W{1'b0}};
                slot_cnt_d  = {DIV_W{1'b0}};
                pend_d      = 1'b0;
            end
        endcase
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clkIn or negedge rstN) begin
        if (!rstN) begin
            state_q     <= ST_IDLE;
            phase_idx_q <= {IDX_W{1'b0}};
            slot_cnt_q  <= {DIV_W{1'b0}};
            div_cur_q   <= DIV_RST_V;
            div_pend_q  <= DIV_RST_V;
            pend_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_idx_q <= phase_idx_d;
            slot_cnt_q  <= slot_cnt_d;
            div_cur_q   <= div_cur_d;
            div_pend_q  <= div_pend_d;
            pend_q      <= pend_d;
        end
    end

    assign bus.phaseClk   = phase_clk_s;
    assign bus.phaseStart = phase_start_s;
    assign bus.cycleDone  = boundary_s;
    assign bus.running    = (state_q == ST_RUN);
    assign bus.divBusy    = pend_q;
endmodule

// File: tb/tb_phase_clock_gen.sv
// Scoreboard bench for phase_clock_gen: three instances (N=2, 3, 4) driven by directed
// per-cycle vectors; a negedge monitor per instance pops and compares expected outputs.
module tb_phase_clock_gen;
    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] ps;
        logic        cd;
        logic        rn;
        logic        bz;
    } exp_t;

    logic clkIn;
    logic rstN;
    int   n_cmp;
    int   n_bad;
    exp_t q2[$];
    exp_t q3[$];
    exp_t q4[$];

    phase_clock_gen_if #(.N_PHASES(2)) if2 ();
    phase_clock_gen_if #(.N_PHASES(3)) if3 ();
    phase_clock_gen_if #(.N_PHASES(4)) if4 ();

    phase_clock_gen #(.N_PHASES(2), .DIV_W(8), .DIV_RESET(1)) dut2 (.clkIn(clkIn), .rstN(rstN), .bus(if2));
    phase_clock_gen #(.N_PHASES(3), .DIV_W(8), .DIV_RESET(2)) dut3 (.clkIn(clkIn), .rstN(rstN), .bus(if3));
    phase_clock_gen #(.N_PHASES(4), .DIV_W(8), .DIV_RESET(1)) dut4 (.clkIn(clkIn), .rstN(rstN), .bus(if4));

    initial clkIn = 1'b0;
    always #5 clkIn = ~clkIn;

    task automatic compare(input string name, input exp_t act, input exp_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got pc=%h ps=%h done=%b run=%b busy=%b, expected pc=%h ps=%h done=%b run=%b busy=%b",
                     name, $time, act.pc, act.ps, act.cd, act.rn, act.bz,
                     exp.pc, exp.ps, exp.cd, exp.rn, exp.bz);
        end
    endtask

    function automatic exp_t act2();
        return '{pc: 16'(if2.phaseClk), ps: 16'(if2.phaseStart), cd: if2.cycleDone, rn: if2.running, bz: if2.divBusy};
    endfunction
    function automatic exp_t act3();
        return '{pc: 16'(if3.phaseClk), ps: 16'(if3.phaseStart), cd: if3.cycleDone, rn: if3.running, bz: if3.divBusy};
    endfunction
    function automatic exp_t act4();
        return '{pc: 16'(if4.phaseClk), ps: 16'(if4.phaseStart), cd: if4.cycleDone, rn: if4.running, bz: if4.divBusy};
    endfunction

    // Monitors: each negedge, pop the expectation pushed for the current cycle.
    always @(negedge clkIn) if (q2.size() > 0) compare("n2", act2(), q2.pop_front());
    always @(negedge clkIn) if (q3.size() > 0) compare("n3", act3(), q3.pop_front());
    always @(negedge clkIn) if (q4.size() > 0) compare("n4", act4(), q4.pop_front());

    // Drive inputs for one cycle and push the outputs expected during that same cycle.
    task automatic cyc(input int d, input bit e, input bit ld, input logic [7:0] v,
                       input logic [15:0] pc, input logic [15:0] ps,
                       input bit cd, input bit rn, input bit bz);
        exp_t x;
        @(posedge clkIn);
        #1;
        x = '{pc: pc, ps: ps, cd: cd, rn: rn, bz: bz};
        case (d)
            2: begin if2.en = e; if2.divLoad = ld; if2.divVal = v; q2.push_back(x); end
            3: begin if3.en = e; if3.divLoad = ld; if3.divVal = v; q3.push_back(x); end
            default: begin if4.en = e; if4.divLoad = ld; if4.divVal = v; q4.push_back(x); end
        endcase
    endtask

    task automatic idle(input int d, input bit e, input bit ld, input logic [7:0] v);
        cyc(d, e, ld, v, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // One full rotation of n slots of dv cycles; en low over offsets [lo_a, lo_b];
    // up to two divLoad strobes at offsets l1/l2 (-1 = none).
    task automatic rot(input int d, input int n, input int dv, input int lo_a, input int lo_b,
                       input int l1, input int v1, input int l2, input int v2);
        logic [15:0] pc;
        logic [7:0]  v;
        bit          bz;
        for (int o = 0; o < n * dv; o++) begin
            pc = 16'd1 << (o / dv);
            v  = (o == l2) ? 8'(v2) : 8'(v1);
            bz = ((l1 >= 0) && (o > l1)) || ((l2 >= 0) && (o > l2));
            cyc(d, !((o >= lo_a) && (o <= lo_b)), (o == l1) || (o == l2), v,
                pc, ((o % dv) == 0) ? pc : 16'd0, (o == n * dv - 1), 1'b1, bz);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rstN  = 1'b0;
        if2.en = 1'b0; if2.divLoad = 1'b0; if2.divVal = 8'd0;
        if3.en = 1'b0; if3.divLoad = 1'b0; if3.divVal = 8'd0;
        if4.en = 1'b0; if4.divLoad = 1'b0; if4.divVal = 8'd0;
        #22;
        compare("reset_n2", act2(), '0);
        compare("reset_n4", act4(), '0);
        rstN = 1'b1;

        // N=2, divide 1: complementary F/2 phases, then stop at a boundary.
        idle(2, 1'b0, 1'b0, 8'd0);
        idle(2, 1'b1, 1'b0, 8'd0);
        rot(2, 2, 1, -1, -1, -1, 0, -1, 0);
        rot(2, 2, 1, -1, -1, -1, 0, -1, 0);
        rot(2, 2, 1, 1, 1, -1, 0, -1, 0);
        idle(2, 1'b0, 1'b0, 8'd0);

        // N=4, divide 3 loaded while idle: period 12, starts at 0,3,6,9.
        idle(4, 1'b0, 1'b1, 8'd3);
        idle(4, 1'b1, 1'b0, 8'd0);
        rot(4, 4, 3, 11, 11, -1, 0, -1, 0);
        idle(4, 1'b0, 1'b0, 8'd0);
        // divVal 0 acts as divide 1.
        idle(4, 1'b0, 1'b1, 8'd0);
        idle(4, 1'b1, 1'b0, 8'd0);
        rot(4, 4, 1, 3, 3, -1, 0, -1, 0);
        idle(4, 1'b0, 1'b0, 8'd0);

        // N=2 divide 2, load 5 in phase 0 slot cycle 1: applies after the boundary.
        idle(2, 1'b0, 1'b1, 8'd2);
        idle(2, 1'b1, 1'b0, 8'd0);
        rot(2, 2, 2, -1, -1, 1, 5, -1, 0);
        rot(2, 2, 5, 9, 9, -1, 0, -1, 0);
        idle(2, 1'b0, 1'b0, 8'd0);
        // Loads 4 then 6 mid-cycle: only 6 applies; then a boundary load of 3 never shows busy.
        idle(2, 1'b1, 1'b0, 8'd0);
        rot(2, 2, 5, -1, -1, 2, 4, 6, 6);
        rot(2, 2, 6, 11, 11, 11, 3, -1, 0);
        idle(2, 1'b0, 1'b0, 8'd0);
        idle(2, 1'b1, 1'b0, 8'd0);
        rot(2, 2, 3, 5, 5, -1, 0, -1, 0);
        idle(2, 1'b0, 1'b0, 8'd0);

        // N=3 divide 2: en dropped in phase 0 finishes the cycle, then idles.
        idle(3, 1'b1, 1'b0, 8'd0);
        rot(3, 3, 2, 0, 5, -1, 0, -1, 0);
        idle(3, 1'b0, 1'b0, 8'd0);
        idle(3, 1'b1, 1'b0, 8'd0);
        // en low then high again before the boundary: no gap.
        rot(3, 3, 2, 1, 3, -1, 0, -1, 0);
        rot(3, 3, 2, 5, 5, -1, 0, -1, 0);
        idle(3, 1'b0, 1'b0, 8'd0);

        // N=4 divide 3 with a pending load of 7, async reset in phase 1 slot count 2.
        idle(4, 1'b0, 1'b1, 8'd3);
        idle(4, 1'b1, 1'b0, 8'd0);
        for (int o = 0; o < 6; o++) begin
            cyc(4, 1'b1, (o == 1), 8'd7, 16'd1 << (o / 3),
                ((o % 3) == 0) ? (16'd1 << (o / 3)) : 16'd0, 1'b0, 1'b1, (o > 1));
        end
        @(negedge clkIn);
        #2;
        rstN = 1'b0;
        if4.en = 1'b0;
        if4.divLoad = 1'b0;
        #1;
        compare("async_reset_n4", act4(), '0);
        @(posedge clkIn);
        #3;
        rstN = 1'b1;
        idle(4, 1'b0, 1'b0, 8'd0);
        idle(4, 1'b1, 1'b0, 8'd0);
        rot(4, 4, 1, -1, -1, -1, 0, -1, 0);
        rot(4, 4, 1, 3, 3, -1, 0, -1, 0);
        idle(4, 1'b0, 1'b0, 8'd0);

        @(negedge clkIn);
        @(negedge clkIn);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/phase_clock_gen.md
# phase_clock_gen

Parametrised N-phase clock-phase generator driven from a single input clock. It produces N_PHASES one-hot rotating phase signals, each high for a runtime-programmable number of input cycles. It supports glitch-free divide-ratio changes at cycle boundaries and clean start/stop. It supersedes the fixed two-phase divider in the uRISC clocking path; N_PHASES=2 with divide 1 reproduces complementary F/2 phases.

## Interface

**Parameters**
- N_PHASES, 2, number of phase outputs; legal values are 2 to 16.
- DIV_W, 8, width of the slot-length (divide) value.
- DIV_RESET, 1, slot length loaded at reset; legal range is 1 to 2^DIV_W-1.

**Ports**
- clkIn, input, 1, the single clock; all logic is on its rising edge.
- rstN, input, 1, asynchronous active-low reset.
- en, input, 1, run request, level-sensitive.
- divVal, input, DIV_W, requested slot length in clkIn cycles; 0 is treated as 1.
- divLoad, input, 1, single-cycle strobe that captures divVal.
- phaseClk, output, N_PHASES, one-hot phase outputs; all zero when idle.
- phaseStart, output, N_PHASES, one-cycle pulse on bit k during the first cycle of slot k.
- cycleDone, output, 1, one-cycle pulse during the last cycle of slot N_PHASES-1.
- running, output, 1, high while in RUN.
- divBusy, output, 1, high while a divide change is pending.

## Operation

**Registers**
- state: IDLE or RUN.
- phaseIdx: 0 to N_PHASES-1.
- slotCnt: DIV_W bits.
- divCur: active slot length.
- divPend: pending slot length, with a pending flag.

**Reset (rstN low, immediate and asynchronous)**
- state=IDLE, phaseIdx=0, slotCnt=0, divCur=DIV_RESET, pending flag=0.
- All outputs are 0.

**IDLE**
- Outputs are all zero.
- divLoad: divCur <= max(divVal,1) on the same edge; divBusy stays 0.
- en=1 sampled: go to RUN with phaseIdx=0, slotCnt=0.

**RUN**
- phaseClk = one-hot(phaseIdx). running=1.
- phaseStart[phaseIdx] = 1 when slotCnt==0.
- Slot end is when slotCnt==divCur-1:
  - if phaseIdx<N_PHASES-1: phaseIdx+1, slotCnt=0.
  - otherwise this is the cycle boundary, and cycleDone=1.
- At the cycle boundary:
  - If the pending flag is set, or divLoad is high this cycle: divCur <= new value and the pending flag clears.
  - en=1: phaseIdx=0 and continue. en=0: go to IDLE, with all outputs 0 on the next cycle.
- en is sampled only at the boundary. Deasserting en mid-cycle finishes the full cycle. Reasserting en before the boundary produces no gap.
- divLoad outside the boundary: divPend <= max(divVal,1), pending flag=1, divBusy=1 from the next cycle. A repeat load overwrites divPend (latest wins).
- divCur never changes mid-cycle, so every slot within one cycle has equal length.

**Width rules**
- slotCnt compares against divCur-1 with no wrap; divCur is always at least 1.
- phaseIdx width is clog2(N_PHASES).

## Timing

- **Start latency:** en sampled high at edge E0 means phaseClk[0]=1 and phaseStart[0]=1 in the cycle after E0.
- **Stop latency:** with en low at the boundary edge Eb, outputs are zero in the cycle after Eb and running=0.
- **Period:** each phase is high for exactly divCur cycles, so the period is N_PHASES*divCur cycles.
- **Phase adjacency:** phases are adjacent; exactly one bit of phaseClk is high in every RUN cycle, with no overlap and no gap.
- **Divide change:** the new value takes effect from the first slot after the next boundary. divBusy falls in the same cycle the new slot begins.
- **Glitch-free outputs:** all outputs are registered, or decoded only from registered state; no output glitches.
- **Reset mid-run:** outputs drop to 0 asynchronously. After rstN rises, the block is in IDLE and needs en sampled high before restarting.

## Test plan

- **Reset and start:** reset, then en=1 with N=2 and divCur=1.
  - Required: phaseClk alternates 01,10,01,... every cycle, starting 01 one cycle after en is sampled.
  - Required: cycleDone is high on each 10 cycle.
- **Multi-phase:** N=4, divVal=3 loaded in IDLE, then en=1.
  - Required: each bit is high for 3 cycles in order 0,1,2,3; period 12.
  - Required: phaseStart pulses at offsets 0,3,6,9.
- **Mid-run divide change:** N=2, divCur=2; divLoad divVal=5 in phase 0, cycle 1.
  - Required: divBusy=1 until the boundary; the current cycle completes at 2+2.
  - Required: the next slots are 5 cycles long; divBusy=0 at the first new slot.
- **Load conditions:**
  - divLoad divVal=0 behaves as divide 1.
  - Two loads (4, then 6) before the boundary: only 6 is applied.
  - A load in the boundary cycle applies at that edge with divBusy never high.
- **Stop and restart:** en drops in phase 0 of a cycle with N=3, divCur=2.
  - Required: phases 1 and 2 complete; outputs are 0 and running=0 after the boundary.
  - en toggling low then high within one cycle produces no gap.
- **Async reset mid-slot:** rstN low in phase 1, slot count 2.
  - Required: phaseClk=0 immediately, without waiting for clkIn.
  - Required: divCur returns to DIV_RESET and the pending flag clears.
